// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, the reset PC and the fetch sequencer state encoding.
package cpu_pkg;

  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_BEQ  = 3'b001;
  localparam logic [2:0] COND_BNE  = 3'b010;
  localparam logic [2:0] COND_BGEZ = 3'b011;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/cpu_next_pc.sv
// Next-PC selection: jump beats taken branch, which beats PC+4; purely combinational.
// No state and no handshake; it is evaluated against the instruction currently held in IR.
module cpu_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        jump,
  input  logic [2:0]  condition,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        taken;
  logic        unused_bits;

  always_comb begin
    pc4    = pc + 32'd4;
    br_off = {{14{ir[15]}}, ir[15:0], 2'b00};
    taken  = 1'b0;
    case (condition)
      COND_NONE: taken = 1'b0;
      COND_BEQ:  taken = alu_zero;
      COND_BNE:  taken = !alu_zero;
      COND_BGEZ: taken = !rs_data[31];
      default:   taken = 1'b0;
    endcase

    if (jump) begin
      next_pc = {pc4[31:28], ir[25:0], 2'b00};
    end else if (taken) begin
      next_pc = pc4 + br_off;
    end else begin
      next_pc = pc4;
    end
  end

  // Opcode field and the low rs bits play no part in PC selection.
  assign unused_bits = &{1'b0, ir[31:26], rs_data[30:0]};

endmodule

// File: rtl/cpu_fetch.sv
// Fetch sequencer IDLE->FETCH->EXEC: 2 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: FETCH holds until imem_ack; EXEC holds IR/PC while stall is high and commits on the first unstalled edge.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Jump,
  input  logic [2:0]  condition,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic        ir_valid,
  output logic [31:0] instr_count
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  instr_count_q, instr_count_d;
  logic [31:0]  next_pc;

  cpu_next_pc u_next_pc (
    .pc        (pc_q),
    .ir        (ir_q),
    .jump      (Jump),
    .condition (condition),
    .alu_zero  (alu_zero),
    .rs_data   (rs_data),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_count_d = instr_count_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_EXEC;
          ir_d    = imem_rdata;
        end
      end
      ST_EXEC: begin
        // Commit edge: decoder/ALU inputs are only consumed here.
        if (!stall) begin
          state_d       = ST_FETCH;
          pc_d          = next_pc;
          instr_count_d = instr_count_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= PC_INIT;
      ir_q          <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign ir_valid    = (state_q == ST_EXEC);
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign IR          = ir_q;
  assign instr_count = instr_count_q;

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch and sequencing unit for the single-cycle CPU: it owns the program counter, fetches each instruction word from instruction memory over a req/ack handshake, and presents it as `IR` to the control decoder. It consumes the decoder's `Jump` and `condition` outputs to select the next PC, closing the loop between instruction memory and decode. It also keeps a retired-instruction counter.

## Interface
- `RESET_PC`, 32'h0000_3000, PC after reset; bits [1:0] are ignored and forced to 00.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `Jump`  in  1  from decoder; J-type jump for the current `IR`
- `condition`  in  3  from decoder; branch condition code for the current `IR`
- `alu_zero`  in  1  ALU zero flag for the current `IR` (used by beq/bne)
- `rs_data`  in  32  register rs value for the current `IR` (used by bgez)
- `stall`  in  1  holds the current instruction uncommitted
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_ack`  in  1  fetch data valid; may be combinational from `imem_req`
- `imem_rdata`  in  32  instruction word
- `IR`  out  32  current instruction to decoder
- `PC`  out  32  address of `IR`
- `ir_valid`  out  1  `IR` valid; the instruction commits on the edge where `ir_valid && !stall`
- `instr_count`  out  32  retired-instruction count

## Operation
- States:
  - IDLE: reset state.
  - FETCH: `imem_req`=1.
  - EXEC: `ir_valid`=1.
- State transitions:
  - IDLE→FETCH unconditionally after the first clock following reset release.
  - FETCH→EXEC on an edge with `imem_ack`=1; `IR` is loaded from `imem_rdata` on that edge.
  - EXEC→FETCH on the commit edge; `PC` is loaded with next_pc on that edge.
  - EXEC holds while `stall`=1, with `IR`, `PC` and `ir_valid` unchanged.
- `imem_addr` = `PC`; it is stable for the whole FETCH state.
- `imem_ack` is ignored outside FETCH, including a late ack arriving after reset.
- next_pc, with pc4 = `PC`+4 (wraps mod 2^32). Priority order:
  1. `Jump`=1: {pc4[31:28], IR[25:0], 2'b00}.
  2. Branch taken: pc4 + (sign-extended IR[15:0] << 2), wraps mod 2^32.
  3. Otherwise: pc4.
- Branch taken, by `condition`:
  - 000: none.
  - 001 beq: taken if `alu_zero`=1.
  - 010 bne: taken if `alu_zero`=0.
  - 011 bgez: taken if `rs_data`[31]=0.
  - 100–111: never taken.
- `Jump`=1 together with a taken condition: the jump wins.
- `instr_count` increments by 1 on each commit and wraps from FFFF_FFFF to 0.
- `Jump`, `condition`, `alu_zero` and `rs_data` are sampled only on the commit edge.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE
  - `PC`=`RESET_PC`&~3
  - `IR`=0 (nop)
  - `ir_valid`=0
  - `imem_req`=0
  - `instr_count`=0
- `imem_req` and `ir_valid` are decoded from the registered state; no combinational path from any input to them.
- Zero-wait memory (ack in the same cycle as req): FETCH lasts 1 cycle, so throughput is 1 instruction per 2 cycles. Each wait cycle of memory adds 1 cycle.
- First `ir_valid` occurs 3 cycles after reset release with zero-wait memory (IDLE, FETCH, EXEC).
- A new `PC` is visible on `imem_addr` the cycle after commit.
- Reset mid-FETCH: `imem_req` drops immediately and the pending fetch is abandoned.
- Reset mid-EXEC: no commit occurs and `instr_count` is not incremented.

## Structure
- Shared package `cpu_pkg` holds:
  - condition codes COND_NONE=3'b000, COND_BEQ=3'b001, COND_BNE=3'b010, COND_BGEZ=3'b011
  - default RESET_PC constant
  - fetch state encoding (IDLE/FETCH/EXEC)
- Sub-module `cpu_next_pc`: combinational next_pc from `PC`, `IR`, `Jump`, `condition`, `alu_zero`, `rs_data`. The FSM, PC/IR registers and counter stay in `cpu_fetch`.

## Test plan
- Reset release, zero-wait memory returning 0x2408_0005 → `imem_addr`=0x3000 in cycle 2; `IR`=0x2408_0005 and `ir_valid`=1 in cycle 3; next fetch address 0x3004; `instr_count`=1.
- Memory ack delayed 3 cycles → `imem_req` held 4 cycles with `imem_addr` stable; `ir_valid` stays 0 until the ack edge; an ack pulse outside FETCH is ignored.
- `PC`=0x3008, IR=0x0800_0C10, `Jump`=1 → next fetch address 0x0000_3040; with `condition`=011 and `rs_data`=0 also asserted, the jump still wins.
- `PC`=0x3010, IR[15:0]=0xFFFE, `condition`=011:
  - `rs_data`=0x8000_0000 → next fetch address 0x3014.
  - `rs_data`=5 → next fetch address 0x300C.
- `stall`=1 for 5 cycles in EXEC → `IR`, `PC` and `ir_valid` held and `instr_count` unchanged; commit occurs on the first edge with `stall`=0.
- `PC`=0xFFFF_FFFC, no jump or branch → wraps to 0x0000_0000. `instr_count` preloaded by running 2^32−1 commits (or forced) → wraps to 0. Asserting `rst_n`=0 mid-FETCH drops `imem_req` the same cycle.
